// File: rtl/venda_pkg.sv
// venda_pkg: shared types and constants for the vending transaction controller.
//   estado_t  : controller state encoding
//   UN_*      : coin values in 25-centavo units
//   PRECO     : price table indexed by product code, 0 = product unavailable
package venda_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CREDIT,
      DISPENSE,
      CHANGE
   } estado_t;

   localparam logic [2:0] UN_CENT25 = 3'd1;
   localparam logic [2:0] UN_CENT50 = 3'd2;
   localparam logic [2:0] UN_REAL1  = 3'd4;

   localparam logic [4:0] PRECO [0:15] = '{
      5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7,  5'd8,  5'd9,
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0,  5'd0
   };

endpackage

// File: rtl/controle_venda_if.sv
// controle_venda_if: keypad/coin side bundle of the vending controller.
//   inputs to controller : codigoProduto, codigo_valido, cent25, cent50, real1, cancelar
//   outputs of controller: credito, liberar, produto_liberado, troco,
//                          moeda_rejeitada, saldo_insuficiente, ocupado
//   modport slave  : the controller
//   modport master : the upstream driver / observer
interface controle_venda_if #(parameter int CREDIT_W = 5);

   logic [3:0]          codigoProduto;
   logic                codigo_valido;
   logic                cent25;
   logic                cent50;
   logic                real1;
   logic                cancelar;
   logic [CREDIT_W-1:0] credito;
   logic                liberar;
   logic [3:0]          produto_liberado;
   logic                troco;
   logic                moeda_rejeitada;
   logic                saldo_insuficiente;
   logic                ocupado;

   modport slave (
      input  codigoProduto, codigo_valido, cent25, cent50, real1, cancelar,
      output credito, liberar, produto_liberado, troco, moeda_rejeitada,
             saldo_insuficiente, ocupado
   );

   modport master (
      output codigoProduto, codigo_valido, cent25, cent50, real1, cancelar,
      input  credito, liberar, produto_liberado, troco, moeda_rejeitada,
             saldo_insuficiente, ocupado
   );

endinterface

// File: rtl/controle_venda.sv
// controle_venda: vending transaction controller (credit, price check, dispense, change).
//   clk   : system clock
//   reset : synchronous active-high reset, clears state and every output
//   bus   : controle_venda_if.slave carrying code/coin/cancel inputs and all
//           registered outputs (credito, liberar, produto_liberado, troco,
//           moeda_rejeitada, saldo_insuficiente, ocupado)
module controle_venda
   import venda_pkg::*;
#(
   parameter int CREDIT_W        = 5,
   parameter int MAX_CREDIT      = 16,
   parameter int DISPENSE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   controle_venda_if.slave  bus
);

   localparam int TW = $clog2(DISPENSE_CYCLES + 1);

   estado_t             estado;
   logic [TW-1:0]       timer;
   logic [2:0]          valor;
   logic                coin_any;
   logic                coin_extra;
   logic                aberto;
   logic                coin_ok;
   logic                compra_ok;
   logic [CREDIT_W:0]   soma;
   logic [CREDIT_W:0]   preco;

   // Highest coin wins; any lower coin in the same cycle is refused.
   assign valor      = bus.real1  ? UN_REAL1  :
                       bus.cent50 ? UN_CENT50 :
                       bus.cent25 ? UN_CENT25 : 3'd0;
   assign coin_any   = bus.real1 | bus.cent50 | bus.cent25;
   assign coin_extra = (bus.real1 & (bus.cent50 | bus.cent25)) | (bus.cent50 & bus.cent25);
   assign aberto     = (estado == IDLE) || (estado == CREDIT);
   assign soma       = {1'b0, bus.credito} + (CREDIT_W+1)'(valor);
   assign preco      = (CREDIT_W+1)'(PRECO[bus.codigoProduto]);
   // A coin arriving with a code or cancel is always refused.
   assign coin_ok    = aberto & coin_any & ~bus.codigo_valido & ~bus.cancelar &
                       (soma <= (CREDIT_W+1)'(MAX_CREDIT));
   assign compra_ok  = (estado == CREDIT) & bus.codigo_valido & ~bus.cancelar &
                       (preco != '0) & ({1'b0, bus.credito} >= preco);

   always_ff @(posedge clk) begin
      if (reset) begin
         estado                 <= IDLE;
         timer                  <= '0;
         bus.credito            <= '0;
         bus.liberar            <= 1'b0;
         bus.produto_liberado   <= '0;
         bus.troco              <= 1'b0;
         bus.moeda_rejeitada    <= 1'b0;
         bus.saldo_insuficiente <= 1'b0;
         bus.ocupado            <= 1'b0;
      end else begin
         bus.moeda_rejeitada    <= coin_any & (~coin_ok | coin_extra);
         bus.saldo_insuficiente <= aberto & bus.codigo_valido & ~bus.cancelar & ~compra_ok;
         case (estado)
            IDLE, CREDIT: begin
               if (estado == CREDIT && bus.cancelar) begin
                  // First change pulse goes out in the cycle right after cancel.
                  estado      <= CHANGE;
                  bus.troco   <= 1'b1;
                  bus.credito <= bus.credito - 1'b1;
                  bus.ocupado <= 1'b1;
               end else if (compra_ok) begin
                  estado               <= DISPENSE;
                  bus.credito          <= bus.credito - CREDIT_W'(preco);
                  bus.produto_liberado <= bus.codigoProduto;
                  bus.liberar          <= 1'b1;
                  bus.ocupado          <= 1'b1;
                  timer                <= TW'(DISPENSE_CYCLES - 1);
               end else if (coin_ok) begin
                  estado      <= CREDIT;
                  bus.credito <= soma[CREDIT_W-1:0];
               end
            end
            DISPENSE: begin
               if (timer != '0) begin
                  timer <= timer - 1'b1;
               end else begin
                  bus.liberar <= 1'b0;
                  if (bus.credito != '0) begin
                     estado      <= CHANGE;
                     bus.troco   <= 1'b1;
                     bus.credito <= bus.credito - 1'b1;
                  end else begin
                     estado      <= IDLE;
                     bus.ocupado <= 1'b0;
                  end
               end
            end
            CHANGE: begin
               // troco doubles as the high/low toggle; credit drops with each high cycle.
               if (bus.troco) begin
                  bus.troco <= 1'b0;
                  if (bus.credito == '0) begin
                     estado      <= IDLE;
                     bus.ocupado <= 1'b0;
                  end
               end else begin
                  bus.troco   <= 1'b1;
                  bus.credito <= bus.credito - 1'b1;
               end
            end
            default: estado <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_controle_venda.sv
// tb_controle_venda: scoreboard-driven bench for controle_venda.
module tb_controle_venda;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   troco_q[$];
   int   lib_q[$];
   int   e_troco;
   int   e_lib;
   logic lib_prev = 1'b0;

   controle_venda_if #(.CREDIT_W(5)) bus();

   controle_venda #(.CREDIT_W(5), .MAX_CREDIT(16), .DISPENSE_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   function automatic int preco(input int c);
      return (c < 14) ? c + 2 : 0;
   endfunction

   // Each troco pulse pops the credit expected after it; each dispense start pops the code.
   always @(negedge clk) begin
      if (bus.troco === 1'b1) begin
         checks++;
         if (troco_q.size() == 0) begin
            errors++;
            $display("FAIL troco_extra credito=%0d required no pulse", bus.credito);
         end else begin
            e_troco = troco_q.pop_front();
            if (bus.credito !== 5'(e_troco)) begin
               errors++;
               $display("FAIL troco_credito got=%0d required=%0d", bus.credito, e_troco);
            end
         end
      end
      if (bus.liberar === 1'b1 && !lib_prev) begin
         checks++;
         if (lib_q.size() == 0) begin
            errors++;
            $display("FAIL liberar_extra produto=%0d required no dispense", bus.produto_liberado);
         end else begin
            e_lib = lib_q.pop_front();
            if (bus.produto_liberado !== 4'(e_lib)) begin
               errors++;
               $display("FAIL produto got=%0d required=%0d", bus.produto_liberado, e_lib);
            end
         end
      end
      lib_prev = (bus.liberar === 1'b1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.codigoProduto = 4'd0;
      bus.codigo_valido = 1'b0;
      bus.cent25        = 1'b0;
      bus.cent50        = 1'b0;
      bus.real1         = 1'b0;
      bus.cancelar      = 1'b0;
   endtask

   task automatic coin(input int v);
      bus.cent25 = (v == 1);
      bus.cent50 = (v == 2);
      bus.real1  = (v == 4);
      tick();
      clear_in();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_in();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bus.credito, bus.liberar, bus.produto_liberado, bus.troco, bus.moeda_rejeitada,
           bus.saldo_insuficiente, bus.ocupado} !== 14'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h required=0", {bus.credito, bus.liberar,
                  bus.produto_liberado, bus.troco, bus.moeda_rejeitada, bus.saldo_insuficiente, bus.ocupado});
      end
   endtask

   task automatic test_compra();
      do_reset();
      coin(4);
      checks++;
      if (bus.credito !== 5'd4) begin errors++; $display("FAIL compra_cred4 got=%0d required=4", bus.credito); end
      coin(2);
      checks++;
      if (bus.credito !== 5'd6) begin errors++; $display("FAIL compra_cred6 got=%0d required=6", bus.credito); end
      lib_q.push_back(3);
      troco_q.push_back(0);
      bus.codigoProduto = 4'd3;
      bus.codigo_valido = 1'b1;
      tick();
      clear_in();
      checks++;
      if ({bus.liberar, bus.ocupado, bus.credito} !== {2'b11, 5'(6 - preco(3))}) begin
         errors++;
         $display("FAIL compra_inicio lib/ocup/cred got=%b/%b/%0d required=1/1/%0d",
                  bus.liberar, bus.ocupado, bus.credito, 6 - preco(3));
      end
      bus.cent25 = 1'b1;
      tick();
      clear_in();
      checks++;
      if ({bus.liberar, bus.moeda_rejeitada, bus.credito} !== {2'b11, 5'd1}) begin
         errors++;
         $display("FAIL compra_moeda_em_dispense lib/rej/cred got=%b/%b/%0d required=1/1/1",
                  bus.liberar, bus.moeda_rejeitada, bus.credito);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (bus.liberar !== 1'b1) begin errors++; $display("FAIL compra_liberar%0d got=%b required=1", i, bus.liberar); end
      end
      tick();
      checks++;
      if ({bus.liberar, bus.troco, bus.ocupado} !== 3'b011) begin
         errors++;
         $display("FAIL compra_troco lib/troco/ocup got=%b/%b/%b required=0/1/1", bus.liberar, bus.troco, bus.ocupado);
      end
      tick();
      checks++;
      if ({bus.troco, bus.ocupado, bus.credito} !== 7'd0) begin
         errors++;
         $display("FAIL compra_fim troco/ocup/cred got=%b/%b/%0d required=0/0/0", bus.troco, bus.ocupado, bus.credito);
      end
   endtask

   task automatic test_saldo();
      do_reset();
      coin(2);
      bus.codigoProduto = 4'd5;
      bus.codigo_valido = 1'b1;
      tick();
      clear_in();
      checks++;
      if ({bus.saldo_insuficiente, bus.credito} !== {1'b1, 5'd2}) begin
         errors++;
         $display("FAIL saldo_preco7 saldo/cred got=%b/%0d required=1/2", bus.saldo_insuficiente, bus.credito);
      end
      tick();
      checks++;
      if (bus.saldo_insuficiente !== 1'b0) begin errors++; $display("FAIL saldo_pulso got=%b required=0", bus.saldo_insuficiente); end
      bus.codigoProduto = 4'd5;
      bus.codigo_valido = 1'b1;
      bus.cent25        = 1'b1;
      tick();
      clear_in();
      checks++;
      if ({bus.saldo_insuficiente, bus.moeda_rejeitada, bus.credito} !== {2'b11, 5'd2}) begin
         errors++;
         $display("FAIL saldo_moeda_junto saldo/rej/cred got=%b/%b/%0d required=1/1/2",
                  bus.saldo_insuficiente, bus.moeda_rejeitada, bus.credito);
      end
      coin(4); coin(4); coin(4); coin(1);
      bus.codigoProduto = 4'd14;
      bus.codigo_valido = 1'b1;
      tick();
      clear_in();
      checks++;
      if ({bus.saldo_insuficiente, bus.liberar, bus.credito} !== {2'b10, 5'd15}) begin
         errors++;
         $display("FAIL saldo_indisponivel saldo/lib/cred got=%b/%b/%0d required=1/0/15",
                  bus.saldo_insuficiente, bus.liberar, bus.credito);
      end
   endtask

   task automatic test_limite();
      do_reset();
      coin(4); coin(4); coin(4); coin(2);
      coin(4);
      checks++;
      if ({bus.moeda_rejeitada, bus.credito} !== {1'b1, 5'd14}) begin
         errors++;
         $display("FAIL limite_rej rej/cred got=%b/%0d required=1/14", bus.moeda_rejeitada, bus.credito);
      end
      coin(2);
      checks++;
      if ({bus.moeda_rejeitada, bus.credito} !== {1'b0, 5'd16}) begin
         errors++;
         $display("FAIL limite_max rej/cred got=%b/%0d required=0/16", bus.moeda_rejeitada, bus.credito);
      end
   endtask

   task automatic test_simultaneas();
      do_reset();
      bus.real1  = 1'b1;
      bus.cent25 = 1'b1;
      tick();
      clear_in();
      checks++;
      if ({bus.moeda_rejeitada, bus.credito} !== {1'b1, 5'd4}) begin
         errors++;
         $display("FAIL simultaneas rej/cred got=%b/%0d required=1/4", bus.moeda_rejeitada, bus.credito);
      end
   endtask

   task automatic test_cancelar();
      do_reset();
      coin(1); coin(1); coin(1);
      troco_q.push_back(2);
      troco_q.push_back(1);
      troco_q.push_back(0);
      bus.cancelar      = 1'b1;
      bus.codigo_valido = 1'b1;
      bus.codigoProduto = 4'd0;
      tick();
      clear_in();
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         checks++;
         if ({bus.troco, bus.ocupado, bus.liberar, bus.saldo_insuficiente} !==
             {(k < 5 && k % 2 == 0), (k < 5), 2'b00}) begin
            errors++;
            $display("FAIL cancelar_k%0d troco/ocup/lib/saldo got=%b/%b/%b/%b required=%b/%b/0/0", k,
                     bus.troco, bus.ocupado, bus.liberar, bus.saldo_insuficiente, (k < 5 && k % 2 == 0), (k < 5));
         end
      end
   endtask

   task automatic test_reset_troco();
      do_reset();
      coin(1); coin(2);
      troco_q.push_back(2);
      troco_q.push_back(1);
      bus.cancelar = 1'b1;
      tick();
      clear_in();
      tick();
      tick();
      checks++;
      if (bus.troco !== 1'b1) begin errors++; $display("FAIL rtroco_segundo got=%b required=1", bus.troco); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({bus.credito, bus.liberar, bus.produto_liberado, bus.troco, bus.moeda_rejeitada,
           bus.saldo_insuficiente, bus.ocupado} !== 14'd0) begin
         errors++;
         $display("FAIL rtroco_zera got=%h required=0", {bus.credito, bus.liberar,
                  bus.produto_liberado, bus.troco, bus.moeda_rejeitada, bus.saldo_insuficiente, bus.ocupado});
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if ({bus.troco, bus.ocupado} !== 2'b00) begin
            errors++;
            $display("FAIL rtroco_apos%0d troco/ocup got=%b/%b required=0/0", k, bus.troco, bus.ocupado);
         end
      end
   endtask

   initial begin
      clear_in();
      test_reset();
      test_compra();
      test_saldo();
      test_limite();
      test_simultaneas();
      test_cancelar();
      test_reset_troco();
      tick();
      checks++;
      if (troco_q.size() != 0 || lib_q.size() != 0) begin
         errors++;
         $display("FAIL pendentes troco=%0d lib=%0d required=0/0", troco_q.size(), lib_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
